sim_bus_initiator: RTL and testbench

- Bus-initiator side of the simple-system device bus (req/gnt/we/be/addr/wdata, rvalid/rdata/err) that simulator_ctrl and the other devices respond on.
- Accepts word commands on a valid/ready port, issues them in order, and tracks outstanding transactions.
- Buffers bus responses, which cannot be back-pressured, and returns them in order on a valid/ready response port.
- Used as an injector for exercising devices without the core, and as a DMA-style host.

---
 rtl/sim_bus_initiator.sv | 195 +++++++++++++++++++
 tb/tb_sim_bus_initiator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_bus_initiator.sv
// Bus initiator for the simple-system device bus.
// In-order command issue, outstanding tracking, buffered responses.
module sim_bus_initiator #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_we_i,
  input  logic [DataWidth/8-1:0] cmd_be_i,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [DataWidth-1:0]   cmd_wdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_we_o,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic                   rsp_timeout_o,
  output logic                   req_o,
  input  logic                   gnt_i,
  output logic                   we_o,
  output logic [DataWidth/8-1:0] be_o,
  output logic [AddrWidth-1:0]   addr_o,
  output logic [DataWidth-1:0]   wdata_o,
  input  logic                   rvalid_i,
  input  logic [DataWidth-1:0]   rdata_i,
  input  logic                   err_i,
  output logic                   busy_o,
  output logic                   locked_o
);

  localparam int unsigned BW = DataWidth / 8;
  localparam int unsigned PW =
    (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] MAX = CW'(MaxOutstanding);
  localparam logic [PW-1:0] LAST = PW'(MaxOutstanding - 1);
  localparam logic [31:0] TO_LAST = 32'(TimeoutCycles) - 32'd1;
  localparam bit TO_EN = (TimeoutCycles != 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 init_q;
  logic                 we_q;
  logic [BW-1:0]        be_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [CW-1:0]        outst_q, outst_d;
  logic [31:0]          tmo_q, tmo_d;

  logic [MaxOutstanding-1:0] tag_q;
  logic [PW-1:0]             tag_wp_q, tag_rp_q;

  logic [MaxOutstanding-1:0] f_we_q, f_err_q, f_to_q;
  logic [DataWidth-1:0]      f_data_q [MaxOutstanding];
  logic [PW-1:0]             f_wp_q, f_rp_q;
  logic [CW-1:0]             f_cnt_q, f_cnt_d;

  logic                 grant, accept, pop, rsp_in, tmo_hit, push;
  logic [CW-1:0]        used;
  logic                 push_we, push_err, push_to;
  logic [DataWidth-1:0] push_data;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign req_o    = (state_q == REQ);
  assign we_o     = we_q;
  assign be_o     = be_q;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign locked_o = (state_q == LOCKED);
  assign busy_o   = req_o || (outst_q != '0) || (f_cnt_q != '0);

  assign rsp_valid_o   = (f_cnt_q != '0);
  assign rsp_we_o      = f_we_q[f_rp_q];
  assign rsp_rdata_o   = f_data_q[f_rp_q];
  assign rsp_err_o     = f_err_q[f_rp_q];
  assign rsp_timeout_o = f_to_q[f_rp_q];

  assign rsp_in  = rvalid_i && (outst_q != '0) && !locked_o;
  assign tmo_hit = TO_EN && (outst_q != '0) && !rvalid_i
                && (tmo_q == TO_LAST) && !locked_o;
  // A request still waiting in REQ already holds a credit; granting it
  // only moves that credit into the outstanding count.
  assign used = outst_q + f_cnt_q + CW'(req_o);

  assign cmd_ready_o = rst_ni && init_q && !locked_o && !tmo_hit
                    && ((state_q == IDLE) || gnt_i) && (used < MAX);

  assign accept = cmd_valid_i && cmd_ready_o;
  assign grant  = req_o && gnt_i && !tmo_hit;
  assign pop    = rsp_valid_o && rsp_ready_i;
  assign push   = rsp_in || tmo_hit;

  // Select what enters the response FIFO this cycle
  always_comb begin
    push_we   = tag_q[tag_rp_q];
    push_err  = 1'b1;
    push_to   = 1'b1;
    push_data = '0;
    if (rsp_in) begin
      push_err  = err_i;
      push_to   = 1'b0;
      push_data = push_we ? '0 : rdata_i;
    end
  end

  // Next state, outstanding count, FIFO count and timeout counter
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (grant) state_d = accept ? REQ : IDLE;
      default: state_d = LOCKED;
    endcase
    if (tmo_hit) state_d = LOCKED;

    outst_d = outst_q + CW'(grant) - CW'(rsp_in);
    if (tmo_hit) outst_d = '0;

    f_cnt_d = f_cnt_q + CW'(push) - CW'(pop);

    tmo_d = tmo_q + 32'd1;
    if (rvalid_i || (outst_q == '0)) tmo_d = '0;
  end

  // Control and request-stage registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      init_q   <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      outst_q  <= '0;
      tmo_q    <= '0;
      f_cnt_q  <= '0;
      tag_wp_q <= '0;
      tag_rp_q <= '0;
      f_wp_q   <= '0;
      f_rp_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      outst_q <= outst_d;
      tmo_q   <= tmo_d;
      f_cnt_q <= f_cnt_d;
      if (accept) begin
        we_q    <= cmd_we_i;
        be_q    <= cmd_be_i;
        addr_q  <= {cmd_addr_i[AddrWidth-1:2], 2'b00};
        wdata_q <= cmd_wdata_i;
      end
      if (tmo_hit) begin
        tag_wp_q <= '0;
        tag_rp_q <= '0;
      end else begin
        if (grant) tag_wp_q <= nxt(tag_wp_q);
        if (rsp_in) tag_rp_q <= nxt(tag_rp_q);
      end
      if (push) f_wp_q <= nxt(f_wp_q);
      if (pop) f_rp_q <= nxt(f_rp_q);
    end
  end

  // Tag and response storage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag_q   <= '0;
      f_we_q  <= '0;
      f_err_q <= '0;
      f_to_q  <= '0;
      for (int i = 0; i < int'(MaxOutstanding); i++) f_data_q[i] <= '0;
    end else begin
      if (grant) tag_q[tag_wp_q] <= we_q;
      if (push) begin
        f_we_q[f_wp_q]   <= push_we;
        f_err_q[f_wp_q]  <= push_err;
        f_to_q[f_wp_q]   <= push_to;
        f_data_q[f_wp_q] <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_sim_bus_initiator.sv
// Directed bench for sim_bus_initiator.
// MaxOutstanding=2, TimeoutCycles=16.
module tb_sim_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [3:0]  cmd_be_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_we_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o;
  logic        req_o, gnt_i, we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i, busy_o, locked_o;

  int checks = 0;
  int errors = 0;

  sim_bus_initiator #(
    .AddrWidth(32), .DataWidth(32),
    .MaxOutstanding(2), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_we_o(rsp_we_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .be_o(be_o),
    .addr_o(addr_o), .wdata_o(wdata_o),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i),
    .busy_o(busy_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0;
    cmd_be_i = 4'h0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0;
    rdata_i = '0; err_i = 1'b0;
    repeat (3) tick();
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_req", req_o, 0);
    chk("rst_rsp", rsp_valid_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_locked", locked_o, 0);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", cmd_ready_o, 0);
    tick();

    // Write 0x41 to 0x0002_0000, immediate grant and response
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_be_i = 4'hF;
    cmd_addr_i = 32'h0002_0000; cmd_wdata_i = 32'h41; gnt_i = 1'b1;
    #1;
    chk("w_ready", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
    #1;
    chk("w_req", req_o, 1);
    chk("w_addr", addr_o, 32'h0002_0000);
    chk("w_wdata", wdata_o, 32'h41);
    chk("w_we", we_o, 1);
    chk("w_be", be_o, 4'hF);
    tick();
    chk("w_req_once", req_o, 0);
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h1234_5678;
    tick();
    rvalid_i = 1'b0;
    #1;
    chk("w_rsp_valid", rsp_valid_o, 1);
    chk("w_rsp_we", rsp_we_o, 1);
    chk("w_rsp_rdata", rsp_rdata_o, 0);
    chk("w_rsp_err", rsp_err_o, 0);
    chk("w_rsp_to", rsp_timeout_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    #1;
    chk("w_rsp_gone", rsp_valid_o, 0);
    chk("w_idle", busy_o, 0);

    // Read of 0x0010_0006 with grant held off for 5 cycles
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h0010_0006;
    cmd_wdata_i = 32'hDEAD_BEEF;
    tick();
    cmd_valid_i = 1'b0; cmd_addr_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("r_req_wait", req_o, 1);
      chk("r_addr_wait", addr_o, 32'h0010_0004);
      chk("r_we_wait", we_o, 0);
      tick();
    end
    gnt_i = 1'b1;
    #1;
    chk("r_req_6", req_o, 1);
    chk("r_addr_6", addr_o, 32'h0010_0004);
    tick();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hCAFE_F00D;
    tick();
    rvalid_i = 1'b0;
    #1;
    chk("r_rsp_valid", rsp_valid_o, 1);
    chk("r_rsp_rdata", rsp_rdata_o, 32'hCAFE_F00D);
    chk("r_rsp_we", rsp_we_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Three back-to-back reads against two credits
    gnt_i = 1'b1; cmd_valid_i = 1'b1; cmd_addr_i = 32'h100;
    #1;
    chk("c_ready1", cmd_ready_o, 1);
    tick();
    cmd_addr_i = 32'h104;
    #1;
    chk("c_ready2", cmd_ready_o, 1);
    tick();
    cmd_addr_i = 32'h108;
    #1;
    chk("c_ready3_blk", cmd_ready_o, 0);
    chk("c_addr2", addr_o, 32'h104);
    tick();
    #1;
    chk("c_req_idle", req_o, 0);
    chk("c_blocked", cmd_ready_o, 0);
    chk("c_busy", busy_o, 1);
    rvalid_i = 1'b1; rdata_i = 32'hAAAA_0001;
    tick();
    rdata_i = 32'hAAAA_0002;
    tick();
    rvalid_i = 1'b0;
    #1;
    chk("c_full_blk", cmd_ready_o, 0);
    chk("c_head1", rsp_rdata_o, 32'hAAAA_0001);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    #1;
    chk("c_ready3", cmd_ready_o, 1);
    chk("c_head2", rsp_rdata_o, 32'hAAAA_0002);
    tick();
    cmd_valid_i = 1'b0;
    #1;
    chk("c_req3", req_o, 1);
    chk("c_addr3", addr_o, 32'h108);
    tick();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hAAAA_0003;
    tick();
    rvalid_i = 1'b0; rsp_ready_i = 1'b1;
    #1;
    chk("c_order2", rsp_rdata_o, 32'hAAAA_0002);
    tick();
    chk("c_order3", rsp_rdata_o, 32'hAAAA_0003);
    tick();
    rsp_ready_i = 1'b0;
    #1;
    chk("c_drained", rsp_valid_o, 0);

    // Two responses buffered while the response port is stalled
    gnt_i = 1'b1; cmd_valid_i = 1'b1; cmd_addr_i = 32'h200;
    tick();
    cmd_addr_i = 32'h204;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h11; err_i = 1'b0;
    tick();
    rdata_i = 32'h22; err_i = 1'b1;
    tick();
    rvalid_i = 1'b0; err_i = 1'b0;
    #1;
    chk("e_valid", rsp_valid_o, 1);
    chk("e_err0", rsp_err_o, 0);
    chk("e_data0", rsp_rdata_o, 32'h11);
    rsp_ready_i = 1'b1;
    tick();
    chk("e_err1", rsp_err_o, 1);
    chk("e_data1", rsp_rdata_o, 32'h22);
    tick();
    rsp_ready_i = 1'b0;
    #1;
    chk("e_empty", rsp_valid_o, 0);
    chk("e_idle", busy_o, 0);

    // Timeout after 16 cycles without rvalid
    gnt_i = 1'b1; cmd_valid_i = 1'b1; cmd_addr_i = 32'h300;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    gnt_i = 1'b0;
    repeat (15) tick();
    chk("t_not_yet", locked_o, 0);
    tick();
    cmd_valid_i = 1'b1; gnt_i = 1'b1;
    #1;
    chk("t_locked", locked_o, 1);
    chk("t_rsp_valid", rsp_valid_o, 1);
    chk("t_rsp_to", rsp_timeout_o, 1);
    chk("t_rsp_err", rsp_err_o, 1);
    chk("t_rsp_rdata", rsp_rdata_o, 0);
    chk("t_ready", cmd_ready_o, 0);
    chk("t_req", req_o, 0);
    cmd_valid_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1;
    rdata_i = 32'h5555_5555;
    tick();
    rvalid_i = 1'b0; rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    #1;
    chk("t_late_ignored", rsp_valid_o, 0);
    chk("t_still_locked", locked_o, 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    chk("t_unlocked", locked_o, 0);
    tick();

    // Reset while a request is pending and one is outstanding
    gnt_i = 1'b1; cmd_valid_i = 1'b1; cmd_addr_i = 32'h400;
    tick();
    cmd_addr_i = 32'h404;
    tick();
    cmd_valid_i = 1'b0; gnt_i = 1'b0;
    #1;
    chk("x_req", req_o, 1);
    chk("x_busy", busy_o, 1);
    rst_ni = 1'b0;
    tick();
    chk("x_req_rst", req_o, 0);
    chk("x_busy_rst", busy_o, 0);
    rst_ni = 1'b1;
    tick();
    rvalid_i = 1'b1; rdata_i = 32'h7777_7777;
    tick();
    rvalid_i = 1'b0;
    tick();
    chk("x_stray", rsp_valid_o, 0);
    chk("x_idle", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
